// File: rtl/unit_protect_seq_pkg.sv
// Shared definitions for the power-unit protection sequencer.
// The state encoding is also used by the telemetry path, so the numeric codes are fixed.
package unit_protect_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  localparam int BLOCK_DLY_US_DEF = 10;
  localparam int BYP_TMO_US_DEF   = 5000;
  localparam int RST_HOLD_US_DEF  = 100;
  localparam int CNT_W_DEF        = 14;

  // Index of each us_tick_timer instance inside the top-level timer bank.
  localparam int TMR_STATE = 0;
  localparam int TMR_HOLD  = 1;
  localparam int TMR_NUM   = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_BLOCK    = 3'd2,
    ST_BYP_WAIT = 3'd3,
    ST_BYPASSED = 3'd4,
    ST_BYP_FAIL = 3'd5
  } seq_state_e;

  // The relay stays closed in every state from the close command onwards.
  function automatic logic byp_closed_state(input seq_state_e s);
    return (s == ST_BYP_WAIT) || (s == ST_BYPASSED) || (s == ST_BYP_FAIL);
  endfunction

endpackage

// File: rtl/unit_protect_seq_if.sv
// Command/feedback and actuator bundle between the sequencer and its surroundings.
interface unit_protect_seq_if;
  import unit_protect_seq_pkg::*;

  logic                   time_1us;
  logic                   start_stop;
  logic                   err_all;
  logic                   byp_req;
  logic                   reset_unit;
  logic                   byp_ok;
  logic                   pwm_en;
  logic                   byp_con;
  logic                   byp_fail;
  logic                   fault_latched;
  logic [SEQ_STATE_W-1:0] seq_state;

  modport slave (
    input  time_1us, start_stop, err_all, byp_req, reset_unit, byp_ok,
    output pwm_en, byp_con, byp_fail, fault_latched, seq_state
  );

  modport master (
    output time_1us, start_stop, err_all, byp_req, reset_unit, byp_ok,
    input  pwm_en, byp_con, byp_fail, fault_latched, seq_state
  );
endinterface

// File: rtl/unit_protect_seq_us_tick_timer.sv
// Saturating microsecond-strobe counter with synchronous clear and a threshold flag.
module us_tick_timer #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q >= limit_i);

endmodule

// File: rtl/unit_protect_seq.sv
// Protection sequencer: gates IGBT drive, then blocks, closes the bypass relay,
// waits for confirmation and supervises the return from bypass.
module unit_protect_seq
  import unit_protect_seq_pkg::*;
#(
  parameter int BLOCK_DLY_US = BLOCK_DLY_US_DEF,
  parameter int BYP_TMO_US   = BYP_TMO_US_DEF,
  parameter int RST_HOLD_US  = RST_HOLD_US_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  unit_protect_seq_if.slave       seq_if
);

  localparam logic [CNT_W-1:0] BLOCK_LIM = CNT_W'(BLOCK_DLY_US);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(BYP_TMO_US);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(RST_HOLD_US);

  seq_state_e state_q, state_d;
  logic       pwm_en_q, pwm_en_d;
  logic       byp_con_q, byp_con_d;
  logic       byp_fail_q, byp_fail_d;
  logic       fault_q, fault_d;

  logic             tmr_clr   [TMR_NUM];
  logic [CNT_W-1:0] tmr_limit [TMR_NUM];
  logic             tmr_done  [TMR_NUM];

  // State timer restarts on every transition; hold timer restarts whenever reset_unit drops.
  assign tmr_clr[TMR_STATE]   = (state_d != state_q);
  assign tmr_limit[TMR_STATE] = (state_q == ST_BLOCK) ? BLOCK_LIM : TMO_LIM;
  assign tmr_clr[TMR_HOLD]    = !seq_if.reset_unit;
  assign tmr_limit[TMR_HOLD]  = HOLD_LIM;

  generate
    for (genvar gi = 0; gi < TMR_NUM; gi++) begin : g_tmr
      us_tick_timer #(
        .CNT_W (CNT_W)
      ) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (tmr_clr[gi]),
        .tick_i  (seq_if.time_1us),
        .limit_i (tmr_limit[gi]),
        .done_o  (tmr_done[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        // A simultaneous err_all and byp_req counts as a fault.
        if (seq_if.err_all) begin
          state_d = ST_BLOCK;
          fault_d = 1'b1;
        end else if (seq_if.byp_req) begin
          state_d = ST_BLOCK;
          fault_d = 1'b0;
        end else if ((state_q == ST_IDLE) && seq_if.start_stop) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && !seq_if.start_stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_BLOCK: begin
        if (tmr_done[TMR_STATE]) begin
          state_d = ST_BYP_WAIT;
        end
      end
      ST_BYP_WAIT: begin
        if (seq_if.byp_ok) begin
          state_d = ST_BYPASSED;
        end else if (tmr_done[TMR_STATE]) begin
          state_d = ST_BYP_FAIL;
        end
      end
      ST_BYPASSED: begin
        if (tmr_done[TMR_HOLD] && !seq_if.err_all && !seq_if.byp_req) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      ST_BYP_FAIL: begin
        state_d = ST_BYP_FAIL;
      end
      default: begin
        state_d = ST_BLOCK;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as seq_state.
    pwm_en_d   = (state_d == ST_RUN);
    byp_con_d  = byp_closed_state(state_d);
    byp_fail_d = (state_d == ST_BYP_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pwm_en_q   <= 1'b0;
      byp_con_q  <= 1'b0;
      byp_fail_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_en_q   <= pwm_en_d;
      byp_con_q  <= byp_con_d;
      byp_fail_q <= byp_fail_d;
      fault_q    <= fault_d;
    end
  end

  assign seq_if.pwm_en        = pwm_en_q;
  assign seq_if.byp_con       = byp_con_q;
  assign seq_if.byp_fail      = byp_fail_q;
  assign seq_if.fault_latched = fault_q;
  assign seq_if.seq_state     = state_q;

endmodule

// File: tb/tb_unit_protect_seq.sv
// Scoreboard bench for unit_protect_seq: each step queues the expected output set,
// which is popped and compared against the DUT once the step has settled.
`timescale 1ns/1ps
module tb_unit_protect_seq;
  import unit_protect_seq_pkg::*;

  localparam int STB_DIV = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    string    tag;
    int       st;
    int       pwm;
    int       con;
    int       fail;
    int       flt;
  } exp_t;

  exp_t exp_q[$];

  unit_protect_seq_if u_if();

  unit_protect_seq u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int st, input int pwm, input int con,
                          input int fail, input int flt);
    exp_t e;
    e.tag = tag; e.st = st; e.pwm = pwm; e.con = con; e.fail = fail; e.flt = flt;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("txn %-14s state=%0d pwm=%0d con=%0d fail=%0d flt=%0d", e.tag,
               u_if.seq_state, u_if.pwm_en, u_if.byp_con, u_if.byp_fail, u_if.fault_latched);
      chk({e.tag, ".state"}, int'(u_if.seq_state), e.st);
      chk({e.tag, ".pwm"},   int'(u_if.pwm_en), e.pwm);
      chk({e.tag, ".con"},   int'(u_if.byp_con), e.con);
      chk({e.tag, ".fail"},  int'(u_if.byp_fail), e.fail);
      chk({e.tag, ".flt"},   int'(u_if.fault_latched), e.flt);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    repeat (n) begin
      u_if.time_1us = 1'b1;
      cyc(1);
      u_if.time_1us = 1'b0;
      cyc(STB_DIV - 1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    u_if.time_1us = 1'b0; u_if.start_stop = 1'b1; u_if.err_all = 1'b0;
    u_if.byp_req = 1'b0;  u_if.reset_unit = 1'b0; u_if.byp_ok = 1'b0;
    cyc(3);
    push_exp("reset", 0, 0, 0, 0, 0); drain();

    // Power-on with start_stop high, fault pulse in RUN.
    rst_n = 1'b1;
    cyc(1);
    push_exp("run", 1, 1, 0, 0, 0); drain();
    u_if.err_all = 1'b1;
    cyc(1);
    u_if.err_all = 1'b0;
    push_exp("err_block", 2, 0, 0, 0, 1); drain();
    u_if.byp_req = 1'b1; u_if.start_stop = 1'b0;
    strobes(9);
    u_if.byp_req = 1'b0; u_if.start_stop = 1'b1;
    push_exp("block_9us", 2, 0, 0, 0, 1); drain();
    strobes(1);
    push_exp("byp_wait", 3, 0, 1, 0, 1); drain();

    // Confirmation after 300 us.
    strobes(300);
    push_exp("wait_300us", 3, 0, 1, 0, 1); drain();
    u_if.byp_ok = 1'b1;
    cyc(1);
    push_exp("bypassed", 4, 0, 1, 0, 1); drain();
    u_if.byp_ok = 1'b0;
    cyc(2);
    push_exp("bypok_drop", 4, 0, 1, 0, 1); drain();

    // Supervised exit: 99 us, 1-clk glitch, then 100 us.
    u_if.reset_unit = 1'b1;
    strobes(99);
    push_exp("hold_99", 4, 0, 1, 0, 1); drain();
    u_if.reset_unit = 1'b0;
    cyc(1);
    u_if.reset_unit = 1'b1;
    strobes(99);
    push_exp("hold_glitch99", 4, 0, 1, 0, 1); drain();
    u_if.err_all = 1'b1;
    strobes(3);
    push_exp("hold_err", 4, 0, 1, 0, 1); drain();
    u_if.err_all = 1'b0; u_if.start_stop = 1'b0;
    cyc(1);
    push_exp("exit_idle", 0, 0, 0, 0, 0); drain();

    // Bypass request without fault, then timeout into BYP_FAIL.
    u_if.reset_unit = 1'b0; u_if.byp_req = 1'b1;
    cyc(1);
    u_if.byp_req = 1'b0;
    push_exp("req_block", 2, 0, 0, 0, 0); drain();
    strobes(10);
    push_exp("req_wait", 3, 0, 1, 0, 0); drain();
    strobes(4999);
    push_exp("tmo_4999", 3, 0, 1, 0, 0); drain();
    strobes(1);
    push_exp("tmo_5000", 5, 0, 1, 1, 0); drain();
    u_if.reset_unit = 1'b1;
    strobes(1000);
    u_if.reset_unit = 1'b0;
    push_exp("fail_terminal", 5, 0, 1, 1, 0); drain();

    // Async reset from BYP_FAIL, then simultaneous err_all/byp_req and coincident confirm.
    rst_n = 1'b0;
    #2;
    push_exp("arst_fail", 0, 0, 0, 0, 0); drain();
    cyc(1);
    rst_n = 1'b1;
    u_if.err_all = 1'b1; u_if.byp_req = 1'b1;
    cyc(1);
    u_if.err_all = 1'b0; u_if.byp_req = 1'b0;
    push_exp("both_block", 2, 0, 0, 0, 1); drain();
    strobes(10);
    strobes(4999);
    u_if.time_1us = 1'b1;
    cyc(1);
    u_if.time_1us = 1'b0; u_if.byp_ok = 1'b1;
    cyc(1);
    u_if.byp_ok = 1'b0;
    push_exp("coincide", 4, 0, 1, 0, 1); drain();

    // Async reset during BYP_WAIT.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    u_if.byp_req = 1'b1;
    cyc(1);
    u_if.byp_req = 1'b0;
    strobes(10);
    push_exp("wait_again", 3, 0, 1, 0, 0); drain();
    rst_n = 1'b0;
    #2;
    push_exp("arst_wait", 0, 0, 0, 0, 0); drain();
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    push_exp("post_reset", 0, 0, 0, 0, 0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
